// File: rtl/codificador_botones_pkg.sv
// codificador_botones_pkg: shared FSM states, defaults and the low-priority button encoder.
package codificador_botones_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, HELD, RELEASE} btn_state_t;
  localparam int DEFAULT_DEBOUNCE = 16;
  localparam int MAX_BTN = 64;
  // Callers pad unused upper bits with ones so they never register as pressed.
  function automatic int pri_encode_low(input logic [MAX_BTN-1:0] pat);
    int r;
    r = 0;
    for (int i = MAX_BTN - 1; i >= 0; i--) if (!pat[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/codificador_botones_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer that resets to the released level (1).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/codificador_botones.sv
// codificador_botones: synchronizes, debounces and priority-encodes an active-low button bank.
module codificador_botones
  import codificador_botones_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  localparam int CODE_W = $clog2(N_BTN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  btn_n,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              press_pulse,
  output logic              release_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTN-1:0] NONE = '1;
  logic [N_BTN-1:0] sync, cand_pat, cand_pat_nxt;
  logic [CODE_W-1:0] pri, cand_code, cand_code_nxt, code_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic released, valid_nxt, press_nxt, release_nxt;
  btn_state_t state, state_nxt;
  for (genvar i = 0; i < N_BTN; i++) begin : g_sync
    sync_2ff u_sync (.clk(clk), .reset(reset), .d(btn_n[i]), .q(sync[i]));
  end
  assign released = (sync == NONE);
  assign pri = CODE_W'(pri_encode_low({{(MAX_BTN - N_BTN){1'b1}}, sync}));
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cand_pat      <= NONE;
      cand_code     <= '0;
      code          <= '0;
      valid         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      cand_pat      <= cand_pat_nxt;
      cand_code     <= cand_code_nxt;
      code          <= code_nxt;
      valid         <= valid_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cand_pat_nxt  = cand_pat;
    cand_code_nxt = cand_code;
    code_nxt      = code;
    valid_nxt     = valid;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    case (state)
      IDLE:
        if (!released) begin
          cand_pat_nxt  = sync;
          cand_code_nxt = pri;
          cnt_nxt       = '0;
          state_nxt     = CHECK;
        end
      CHECK:
        if (released) state_nxt = IDLE;
        else if (sync != cand_pat) begin
          cand_pat_nxt  = sync;
          cand_code_nxt = pri;
          cnt_nxt       = '0;
        end else if (cnt == CNT_MAX) begin
          code_nxt  = cand_code;
          valid_nxt = 1'b1;
          press_nxt = 1'b1;
          state_nxt = HELD;
        end else cnt_nxt = cnt + 1'b1;
      HELD:
        if (released) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      RELEASE:
        if (!released) state_nxt = HELD;
        else if (cnt == CNT_MAX) begin
          valid_nxt   = 1'b0;
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end else cnt_nxt = cnt + 1'b1;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_codificador_botones.sv
// tb_codificador_botones: directed stimulus checked against a sample-run-length model of the encoder.
module tb_codificador_botones;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] btn_n = '0;
  logic [1:0] code;
  logic valid, press_pulse, release_pulse;
  int n_chk = 0, n_fail = 0;
  int press_cnt = 0, release_cnt = 0, valid_hi = 0;

  codificador_botones #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .code(code), .valid(valid),
    .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a press is accepted once the synchronized pattern has been the same
  // non-released value for D+1 consecutive samples; a release once all-ones has
  // been seen for D+1 consecutive samples while held.
  logic [N-1:0] m_s1 = '1, m_s2 = '1, m_prev = '1, m_cur;
  int m_run = 0, m_rel = 0;
  bit m_held = 0, started = 0;
  logic [1:0] e_code = '0;
  bit e_valid = 0, e_press = 0, e_release = 0;

  function automatic logic [1:0] lowest_zero(input logic [N-1:0] p);
    for (int k = 0; k < N; k++) if (p[k] == 1'b0) return 2'(k);
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    started = 1;
    e_press = 0;
    e_release = 0;
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_prev = '1;
      m_run = 0; m_rel = 0; m_held = 0;
      e_code = '0; e_valid = 0;
    end else begin
      m_cur = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_n;
      if (!m_held) begin
        if (m_cur == '1) m_run = 0;
        else begin
          m_run = (m_cur == m_prev) ? m_run + 1 : 1;
          if (m_run == D + 1) begin
            m_held = 1; m_run = 0; m_rel = 0;
            e_code = lowest_zero(m_cur); e_valid = 1; e_press = 1;
          end
        end
      end else begin
        m_rel = (m_cur == '1) ? m_rel + 1 : 0;
        if (m_rel == D + 1) begin
          m_held = 0; m_rel = 0;
          e_valid = 0; e_release = 1;
        end
      end
      m_prev = m_cur;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("code", code, e_code);
      chk("valid", valid, e_valid);
      chk("press_pulse", press_pulse, e_press);
      chk("release_pulse", release_pulse, e_release);
      chk("pulse_exclusive", press_pulse & release_pulse, 0);
      press_cnt += press_pulse;
      release_cnt += release_pulse;
      valid_hi += valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0, r0, v0;
  initial begin
    // 1: reset with every button pressed
    reset = 1'b1; btn_n = 4'b0000;
    cyc(3);
    chk("rst_code", code, 0);
    chk("rst_valid", valid, 0);
    chk("rst_press", press_pulse, 0);
    reset = 1'b0; btn_n = 4'b1111;
    cyc(10);
    chk("idle_no_press", press_cnt, 0);
    chk("idle_no_release", release_cnt, 0);
    // 2: single press, press_pulse after edge 7
    btn_n = 4'b1101;
    cyc(6);
    chk("t2_press_early", press_pulse, 0);
    cyc(1);
    chk("t2_press", press_pulse, 1);
    chk("t2_code", code, 1);
    chk("t2_valid", valid, 1);
    cyc(1);
    chk("t2_press_once", press_pulse, 0);
    cyc(12);
    chk("t2_press_cnt", press_cnt, 1);
    btn_n = 4'b1111;
    cyc(6);
    chk("t2_rel_early", release_pulse, 0);
    cyc(1);
    chk("t2_release", release_pulse, 1);
    chk("t2_rel_valid", valid, 0);
    chk("t2_rel_code", code, 1);
    cyc(5);
    chk("t2_release_cnt", release_cnt, 1);
    // 3: simultaneous press, then pattern change while held
    p0 = press_cnt;
    btn_n = 4'b1010;
    cyc(7);
    chk("t3_press", press_pulse, 1);
    chk("t3_code", code, 0);
    btn_n = 4'b1011;
    cyc(15);
    chk("t3_frozen_code", code, 0);
    chk("t3_one_press", press_cnt - p0, 1);
    btn_n = 4'b1111;
    cyc(12);
    // 4: bounce rejection
    p0 = press_cnt; v0 = valid_hi;
    for (int k = 0; k < 5; k++) begin
      btn_n = 4'b1110; cyc(2);
      btn_n = 4'b1111; cyc(2);
    end
    cyc(10);
    chk("t4_no_press", press_cnt - p0, 0);
    chk("t4_never_valid", valid_hi - v0, 0);
    // 5: release glitch while held on button 3
    btn_n = 4'b0111;
    cyc(10);
    chk("t5_code", code, 3);
    r0 = release_cnt;
    btn_n = 4'b1111; cyc(2);
    btn_n = 4'b0111; cyc(10);
    chk("t5_valid", valid, 1);
    chk("t5_no_release", release_cnt - r0, 0);
    btn_n = 4'b1111;
    cyc(12);
    chk("t5_final_release", release_cnt - r0, 1);
    // 6: reset on edge 4 while the press is in CHECK
    p0 = press_cnt;
    btn_n = 4'b1011;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t6_rst_valid", valid, 0);
    cyc(6);
    chk("t6_press_early", press_pulse, 0);
    cyc(1);
    chk("t6_press", press_pulse, 1);
    chk("t6_code", code, 2);
    cyc(3);
    chk("t6_single_press", press_cnt - p0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
